// File: rtl/instr_scheduler.sv
// Instruction scheduler: a small FIFO of host instructions feeding a
// processor through a three-phase handshake (IDLE -> PREP -> RUN), with a
// completion counter and a sticky abort flag for instructions that time out.
module instr_scheduler #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [33:0] in_instr,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [33:0] proc_instr,
   output logic        proc_sig,
   input  logic        proc_done,
   output logic        busy,
   output logic [7:0]  issued_count,
   output logic        timeout_err
);

   localparam int DATA_W = 34;
   localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW     = AW + 1;
   localparam int WW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, PREP, RUN} state_t;

   state_t              state, state_nxt;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [CW-1:0]       count;
   logic [WW-1:0]       wait_cnt;
   logic                push, pop;
   logic                run_done, run_timeout;

   // The host may hold its word while full; a pop in the same cycle does
   // not open a slot early because ready depends only on registered count.
   assign in_ready = (count < CW'(DEPTH));
   assign push     = in_valid && in_ready;
   assign busy     = (state != IDLE) || (count != '0);

   // Next-state and handshake decode; RUN ends on completion or on the last
   // permitted wait cycle, with completion winning a tie.
   always_comb begin
      state_nxt   = state;
      pop         = 1'b0;
      proc_sig    = 1'b0;
      run_done    = 1'b0;
      run_timeout = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               pop       = 1'b1;
               state_nxt = PREP;
            end
         end
         PREP: begin
            state_nxt = RUN;
         end
         RUN: begin
            proc_sig = 1'b1;
            if (proc_done) begin
               run_done  = 1'b1;
               state_nxt = IDLE;
            end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
               run_timeout = 1'b1;
               state_nxt   = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Queue storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_instr;
   end

   // Queue pointers and occupancy; power-of-two depth makes wrap implicit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Instruction register to the processor; holds until the next pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      proc_instr <= '0;
      else if (pop) proc_instr <= mem[rd_ptr];
   end

   // RUN wait counter; zero whenever not running so each RUN starts fresh.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                    wait_cnt <= '0;
      else if (state == RUN && state_nxt == RUN)  wait_cnt <= wait_cnt + WW'(1);
      else                                        wait_cnt <= '0;
   end

   // Completion counter (wraps) and sticky abort flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issued_count <= '0;
         timeout_err  <= 1'b0;
      end else begin
         if (run_done)    issued_count <= issued_count + 8'd1;
         if (run_timeout) timeout_err  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_instr_scheduler.sv
// Self-checking bench for instr_scheduler: a directed vector table, hand
// sequences for the multi-cycle corner cases, and randomized traffic checked
// against a queue-based reference model.
module tb_instr_scheduler;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 31;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [33:0] in_instr = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [33:0] proc_instr;
   logic        proc_sig;
   logic        proc_done = 1'b0;
   logic        busy;
   logic [7:0]  issued_count;
   logic        timeout_err;

   int n_checks = 0;
   int n_errors = 0;

   instr_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_instr     (in_instr),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .proc_instr   (proc_instr),
      .proc_sig     (proc_sig),
      .proc_done    (proc_done),
      .busy         (busy),
      .issued_count (issued_count),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   // Reference model: pending words in a queue, plus the age (cycles since
   // pop) of the instruction handed to the processor. Age 1 is the prepare
   // cycle; age n>=2 is execute cycle n-1.
   logic [33:0] mq[$];
   bit          m_inflight;
   int          m_age;
   logic [33:0] m_instr;
   logic [7:0]  m_issued;
   logic        m_terr;

   function automatic logic exp_sig();
      return m_inflight && (m_age >= 2);
   endfunction

   task automatic model_reset();
      mq.delete();
      m_inflight = 0;
      m_age      = 0;
      m_instr    = '0;
      m_issued   = '0;
      m_terr     = 1'b0;
   endtask

   task automatic model_tick(input logic v, input logic [33:0] i, input logic d);
      bit do_push;
      do_push = v && (mq.size() < DEPTH);
      if (m_inflight) begin
         if (m_age >= 2) begin
            if (d) begin
               m_issued   = m_issued + 8'd1;
               m_inflight = 0;
            end else if (m_age - 1 == TIMEOUT) begin
               m_terr     = 1'b1;
               m_inflight = 0;
            end else begin
               m_age++;
            end
         end else begin
            m_age++;
         end
      end else if (mq.size() > 0) begin
         m_instr    = mq.pop_front();
         m_inflight = 1;
         m_age      = 1;
      end
      if (do_push) mq.push_back(i);
   endtask

   task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, compare outputs to the model mid-cycle, then
   // advance the model across the rising edge.
   task automatic step(input logic v, input logic [33:0] i, input logic d);
      in_valid  = v;
      in_instr  = i;
      proc_done = d;
      @(negedge clk);
      chk("in_ready",     in_ready,     (mq.size() < DEPTH));
      chk("proc_sig",     proc_sig,     exp_sig());
      chk("busy",         busy,         m_inflight || (mq.size() > 0));
      chk("proc_instr",   proc_instr,   m_instr);
      chk("issued_count", issued_count, m_issued);
      chk("timeout_err",  timeout_err,  m_terr);
      @(posedge clk);
      model_tick(v, i, d);
      #1;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      in_instr  = '0;
      proc_done = 1'b0;
      rst       = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        v;
      logic [33:0] i;
      logic        d;
      logic        rdy;
      logic        sig;
      logic        bsy;
      logic [33:0] pi;
      logic [7:0]  cnt;
      logic        terr;
   } vec_t;

   vec_t tbl[12];

   initial begin
      logic [33:0] w[5];
      logic [33:0] cur;
      bit          pend;
      bit          acc;
      logic        d;
      int          k;

      // Basic issue with immediate completion, then done pulses in IDLE and PREP.
      tbl[0]  = '{1'b1, 34'h1234,        1'b0, 1'b1, 1'b0, 1'b0, 34'h0,          8'd0, 1'b0};
      tbl[1]  = '{1'b0, 34'h0,           1'b0, 1'b1, 1'b0, 1'b1, 34'h0,          8'd0, 1'b0};
      tbl[2]  = '{1'b0, 34'h0,           1'b0, 1'b1, 1'b0, 1'b1, 34'h1234,       8'd0, 1'b0};
      tbl[3]  = '{1'b0, 34'h0,           1'b1, 1'b1, 1'b1, 1'b1, 34'h1234,       8'd0, 1'b0};
      tbl[4]  = '{1'b0, 34'h0,           1'b1, 1'b1, 1'b0, 1'b0, 34'h1234,       8'd1, 1'b0};
      tbl[5]  = '{1'b1, 34'h2_0000_0001, 1'b1, 1'b1, 1'b0, 1'b0, 34'h1234,       8'd1, 1'b0};
      tbl[6]  = '{1'b0, 34'h0,           1'b1, 1'b1, 1'b0, 1'b1, 34'h1234,       8'd1, 1'b0};
      tbl[7]  = '{1'b0, 34'h0,           1'b1, 1'b1, 1'b0, 1'b1, 34'h2_0000_0001, 8'd1, 1'b0};
      tbl[8]  = '{1'b0, 34'h0,           1'b0, 1'b1, 1'b1, 1'b1, 34'h2_0000_0001, 8'd1, 1'b0};
      tbl[9]  = '{1'b0, 34'h0,           1'b1, 1'b1, 1'b1, 1'b1, 34'h2_0000_0001, 8'd1, 1'b0};
      tbl[10] = '{1'b0, 34'h0,           1'b0, 1'b1, 1'b0, 1'b0, 34'h2_0000_0001, 8'd2, 1'b0};
      tbl[11] = '{1'b0, 34'h0,           1'b0, 1'b1, 1'b0, 1'b0, 34'h2_0000_0001, 8'd2, 1'b0};

      do_reset();

      // Reset state.
      chk("rst in_ready",     in_ready,     1'b1);
      chk("rst proc_sig",     proc_sig,     1'b0);
      chk("rst busy",         busy,         1'b0);
      chk("rst proc_instr",   proc_instr,   34'h0);
      chk("rst issued_count", issued_count, 8'd0);
      chk("rst timeout_err",  timeout_err,  1'b0);

      // Directed table.
      for (int r = 0; r < 12; r++) begin
         in_valid  = tbl[r].v;
         in_instr  = tbl[r].i;
         proc_done = tbl[r].d;
         @(negedge clk);
         chk($sformatf("tbl%0d in_ready", r),     in_ready,     tbl[r].rdy);
         chk($sformatf("tbl%0d proc_sig", r),     proc_sig,     tbl[r].sig);
         chk($sformatf("tbl%0d busy", r),         busy,         tbl[r].bsy);
         chk($sformatf("tbl%0d proc_instr", r),   proc_instr,   tbl[r].pi);
         chk($sformatf("tbl%0d issued_count", r), issued_count, tbl[r].cnt);
         chk($sformatf("tbl%0d timeout_err", r),  timeout_err,  tbl[r].terr);
         @(posedge clk);
         model_tick(tbl[r].v, tbl[r].i, tbl[r].d);
         #1;
      end

      // Five back-to-back words with the host holding while full, then drain
      // with immediate completion; order is checked through proc_instr.
      w[0] = 34'h0_0000_00A0; w[1] = 34'h1_0000_00A1; w[2] = 34'h2_0000_00A2;
      w[3] = 34'h3_0000_00A3; w[4] = 34'h0_FFFF_00A4;
      k = 0;
      for (int c = 0; c < 8; c++) begin
         acc = (k < 5) && (mq.size() < DEPTH);
         step(k < 5, w[(k < 5) ? k : 0], 1'b0);
         if (acc) k++;
      end
      chk("full in_ready", in_ready, 1'b0);
      for (int c = 0; c < 30; c++) step(1'b0, 34'h0, exp_sig());
      chk("order issued_count", issued_count, 8'd7);

      // Never complete: abort after the last permitted RUN cycle.
      step(1'b1, 34'h1_2345_6789, 1'b0);
      for (int c = 0; c < 40; c++) step(1'b0, 34'h0, 1'b0);
      chk("abort timeout_err",  timeout_err,  1'b1);
      chk("abort issued_count", issued_count, 8'd7);
      step(1'b1, 34'h0_0000_0BEE, 1'b0);
      for (int c = 0; c < 6; c++) step(1'b0, 34'h0, exp_sig());
      chk("after abort issued", issued_count, 8'd8);
      chk("after abort sticky", timeout_err,  1'b1);

      // Completion on the final RUN cycle wins over the timeout.
      do_reset();
      step(1'b1, 34'h0_0000_0777, 1'b0);
      step(1'b0, 34'h0, 1'b0);
      step(1'b0, 34'h0, 1'b0);
      for (int c = 0; c < TIMEOUT - 1; c++) step(1'b0, 34'h0, 1'b0);
      step(1'b0, 34'h0, 1'b1);
      step(1'b0, 34'h0, 1'b0);
      chk("edge issued_count", issued_count, 8'd1);
      chk("edge timeout_err",  timeout_err,  1'b0);

      // Asynchronous reset mid-RUN with three words still queued.
      for (int c = 0; c < 4; c++) step(1'b1, 34'(c + 16), 1'b0);
      in_valid = 1'b0; proc_done = 1'b0;
      @(negedge clk);
      chk("pre-rst proc_sig", proc_sig, 1'b1);
      chk("pre-rst in_ready", in_ready, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("async proc_sig",     proc_sig,     1'b0);
      chk("async in_ready",     in_ready,     1'b1);
      chk("async busy",         busy,         1'b0);
      chk("async proc_instr",   proc_instr,   34'h0);
      chk("async issued_count", issued_count, 8'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      for (int c = 0; c < 5; c++) step(1'b0, 34'h0, 1'b0);

      // Randomized traffic; the host holds each word until it is accepted.
      pend = 0;
      cur  = '0;
      for (int n = 0; n < 1500; n++) begin
         if (!pend) begin
            pend = ($urandom_range(0, 2) != 0);
            cur  = {2'($urandom_range(0, 3)), 32'($urandom)};
         end
         if (n < 700) d = ($urandom_range(0, 19) == 0);
         else         d = ($urandom_range(0, 1) == 0);
         acc = pend && (mq.size() < DEPTH);
         step(pend, cur, d);
         if (acc) pend = 0;
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
